quadcap_frame_tx: RTL and testbench

Downstream framing stage for the four-channel capture path. It drains 16-bit packed words from the capture FIFO's read port using the read-pulse / data-valid handshake. It wraps them into byte frames (header, sequence number, length, payload, checksum) and emits them on an 8-bit valid/ready stream toward the UART/host TX engine.

---
 rtl/quadcap_frame_pkg.sv | 24 ++
 rtl/quadcap_frame_tx.sv | 188 ++++++++++++++++++
 tb/tb_quadcap_frame_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadcap_frame_pkg.sv
// Shared types and constants for the capture-path frame transmitter.
package quadcap_frame_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StSeq,
    StLenH,
    StLenL,
    StReq,
    StWait,
    StBhi,
    StBlo,
    StCsum
  } state_e;

  localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

  // Cycles from data_re_pulse to data_valid on the capture FIFO read port.
  localparam int unsigned FIFO_RD_LATENCY = 3;

endpackage

// File: rtl/quadcap_frame_tx.sv
// Frame transmitter: drains the capture FIFO one word at a time and emits
// header, sequence, length, payload and checksum bytes on a valid/ready byte stream.
module quadcap_frame_tx
  import quadcap_frame_pkg::*;
#(
  parameter int unsigned MAX_WORDS  = 512,
  parameter logic [7:0]  HDR0       = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1       = HDR1_DEFAULT,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  input  logic        fifo_empty,
  input  logic [13:0] fifo_level,
  input  logic        cap_done,
  output logic        data_re_pulse,
  input  logic        data_valid,
  input  logic [15:0] data_word,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  seq,
  output logic        err
);

  localparam logic [13:0] MaxWords = 14'(MAX_WORDS);
  localparam logic [7:0]  WaitLast = 8'(RD_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [13:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  wait_q, wait_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        re_pulse_q, re_pulse_d;
  logic        busy_q, busy_d;
  logic [7:0]  seq_q, seq_d;
  logic        err_q, err_d;

  logic        accept;
  logic        start;
  logic        timeout;
  logic [13:0] n_start;
  logic [7:0]  csum_add;

  assign accept   = tx_valid_q & tx_ready;
  assign csum_add = csum_q + tx_data_q;
  assign n_start  = (fifo_level >= MaxWords) ? MaxWords : fifo_level;
  assign start    = enable && (n_start != '0) &&
                    ((fifo_level >= MaxWords) || (cap_done && !fifo_empty));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    re_pulse_d = 1'b0;
    busy_d     = busy_q;
    seq_d      = seq_q;
    timeout    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StHdr0;
          cnt_d      = n_start;
          csum_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = HDR0;
          busy_d     = 1'b1;
        end
      end
      StHdr0: if (accept) begin
        state_d   = StHdr1;
        tx_data_d = HDR1;
      end
      StHdr1: if (accept) begin
        state_d   = StSeq;
        tx_data_d = seq_q;
      end
      StSeq: if (accept) begin
        state_d   = StLenH;
        tx_data_d = {2'b00, cnt_q[13:8]};
        csum_d    = csum_add;
      end
      StLenH: if (accept) begin
        state_d   = StLenL;
        tx_data_d = cnt_q[7:0];
        csum_d    = csum_add;
      end
      StLenL: if (accept) begin
        state_d    = StReq;
        tx_valid_d = 1'b0;
        re_pulse_d = 1'b1;
        csum_d     = csum_add;
      end
      StReq: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (data_valid) begin
          state_d    = StBhi;
          hold_d     = data_word;
          tx_valid_d = 1'b1;
          tx_data_d  = data_word[15:8];
        end else if (wait_q == WaitLast) begin
          // Abandon the frame: the receiver sees a truncated frame without checksum.
          timeout = 1'b1;
          state_d = StIdle;
          busy_d  = 1'b0;
          seq_d   = seq_q + 8'd1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StBhi: if (accept) begin
        state_d   = StBlo;
        tx_data_d = hold_q[7:0];
        csum_d    = csum_add;
      end
      StBlo: if (accept) begin
        csum_d = csum_add;
        cnt_d  = cnt_q - 14'd1;
        if (cnt_q != 14'd1) begin
          state_d    = StReq;
          tx_valid_d = 1'b0;
          re_pulse_d = 1'b1;
        end else begin
          state_d   = StCsum;
          tx_data_d = csum_add;
        end
      end
      StCsum: if (accept) begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        seq_d      = seq_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    err_d = timeout | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      csum_q     <= '0;
      hold_q     <= '0;
      wait_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      re_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
      seq_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      re_pulse_q <= re_pulse_d;
      busy_q     <= busy_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
    end
  end

  assign data_re_pulse = re_pulse_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
  assign seq           = seq_q;
  assign err           = err_q;

endmodule

// File: tb/tb_quadcap_frame_tx.sv
// Bench for quadcap_frame_tx: FIFO responder, byte collector and a frame-level
// reference model built from the framing rules.
`timescale 1ns/1ps
module tb_quadcap_frame_tx;
  import quadcap_frame_pkg::*;

  localparam int unsigned MaxW = 4;
  localparam int unsigned RdTo = 15;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int level;
    bit capd;
    bit empty;
    bit bp;
    bit fixed;
    int exp_n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, enable, err_clr, fifo_empty, cap_done;
  logic [13:0] fifo_level;
  logic        data_valid, tx_ready;
  logic [15:0] data_word;
  logic        data_re_pulse, tx_valid, busy, err;
  logic [7:0]  tx_data, seq;

  quadcap_frame_tx #(.MAX_WORDS(MaxW), .RD_TIMEOUT(RdTo)) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .cap_done(cap_done), .data_re_pulse(data_re_pulse),
    .data_valid(data_valid), .data_word(data_word), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .seq(seq), .err(err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Written only by the main sequence.
  int          tests = 0, fails = 0;
  bit          bp_mode = 1'b0;
  int          supp_rd = -1;
  int          rd_base = 0;
  logic [15:0] wtab [16];

  // Written only by the monitor.
  int          read_cnt = 0, last_pulse_cyc = -10, due = -1;
  logic [15:0] pword = '0;
  logic [7:0]  rx[$];
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;
  int          stall_viol = 0, stall_seen = 0, proto_viol = 0;
  logic [3:0]  widx;

  // FIFO read-data responder and sink readiness, driven just after each rising edge.
  initial begin
    tx_ready = 1'b1; data_valid = 1'b0; data_word = '0;
    forever begin
      @(posedge clk); #1;
      tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == due) begin
        data_valid = 1'b1; data_word = pword;
      end else begin
        data_valid = 1'b0; data_word = 16'($urandom);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (data_re_pulse) begin
      if (cyc == last_pulse_cyc + 1 || cyc <= due) proto_viol++;
      widx = 4'(read_cnt - rd_base);
      if (read_cnt != supp_rd) begin
        due   = cyc + int'(FIFO_RD_LATENCY);
        pword = wtab[widx];
      end
      last_pulse_cyc = cyc;
      read_cnt++;
    end
    if (!rst) begin
      if (stall_prev) begin
        stall_seen++;
        if (!tx_valid || tx_data != prev_data) stall_viol++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) rx.push_back(tx_data);
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_frame(input string name, input int start, input bq_t want);
    int got_n;
    int bad;
    got_n = rx.size() - start;
    bad = -1;
    for (int i = 0; i < want.size() && i < got_n; i++)
      if (bad < 0 && rx[start + i] != want[i]) bad = i;
    tests++;
    if (got_n != want.size() || bad >= 0) begin
      fails++;
      if (bad >= 0)
        $display("FAIL %s: byte %0d got 0x%02h, expected 0x%02h", name, bad, rx[start + bad],
                 want[bad]);
      else
        $display("FAIL %s: got %0d bytes, expected %0d bytes", name, got_n, want.size());
    end
  endtask

  // Expected byte stream: sync, seq, length, first nw payload words, optional checksum.
  function automatic bq_t model_frame(input logic [7:0] s, input int n, input int nw,
                                      input bit with_csum);
    bq_t q;
    int  sum;
    q = {};
    q.push_back(HDR0_DEFAULT);
    q.push_back(HDR1_DEFAULT);
    q.push_back(s);
    q.push_back(8'(n / 256));
    q.push_back(8'(n % 256));
    sum = int'(s) + n / 256 + n % 256;
    for (int i = 0; i < nw; i++) begin
      q.push_back(wtab[i][15:8]);
      q.push_back(wtab[i][7:0]);
      sum += int'(wtab[i][15:8]) + int'(wtab[i][7:0]);
    end
    if (with_csum) q.push_back(8'(sum % 256));
    return q;
  endfunction

  task automatic load_words(input bit fixed);
    for (int i = 0; i < 16; i++) wtab[i] = 16'($urandom);
    if (fixed) begin
      wtab[0] = 16'h1234; wtab[1] = 16'hABCD; wtab[2] = 16'h0001; wtab[3] = 16'hFF00;
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      samp();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int nb);
    nb = 1;
    for (int i = 0; i < 800; i++) begin
      samp();
      if (!busy) break;
      nb++;
    end
  endtask

  task automatic run_frame(output bit ok, output int nb);
    nb = 0;
    wait_busy(ok);
    if (ok) begin
      drive(); fifo_level = '0; cap_done = 1'b0; fifo_empty = 1'b1;
      wait_idle(nb);
    end
  endtask

  vec_t       vecs [8];
  logic [7:0] exp_seq;
  int         rx0, nb, t;
  bit         ok, any_busy;

  initial begin
    vecs[0] = '{4,   0, 0, 0, 1, 4};  // full frame, known words
    vecs[1] = '{3,   1, 0, 0, 0, 3};  // partial flush on cap_done
    vecs[2] = '{4,   0, 0, 1, 1, 4};  // known words under backpressure
    vecs[3] = '{600, 0, 0, 1, 0, 4};  // level above MAX_WORDS clamps N
    vecs[4] = '{1,   1, 0, 0, 0, 1};  // single-word flush
    vecs[5] = '{3,   0, 0, 0, 0, 0};  // below MAX_WORDS, no cap_done
    vecs[6] = '{0,   1, 0, 0, 0, 0};  // N=0 never starts
    vecs[7] = '{5,   1, 0, 0, 0, 4};

    rst = 1'b1; enable = 1'b0; err_clr = 1'b0; fifo_empty = 1'b1;
    fifo_level = '0; cap_done = 1'b0; exp_seq = '0;
    load_words(1'b0);
    repeat (3) samp();
    check("reset_re_pulse", int'(data_re_pulse), 0);
    check("reset_tx_valid", int'(tx_valid), 0);
    check("reset_tx_data", int'(tx_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_seq", int'(seq), 0);
    check("reset_err", int'(err), 0);
    drive(); rst = 1'b0;
    repeat (2) drive();

    for (int v = 0; v < 8; v++) begin
      load_words(vecs[v].fixed);
      rd_base = read_cnt;
      rx0 = rx.size();
      drive();
      bp_mode = vecs[v].bp; enable = 1'b1; fifo_level = 14'(vecs[v].level);
      cap_done = vecs[v].capd; fifo_empty = vecs[v].empty;
      if (vecs[v].exp_n == 0) begin
        any_busy = 1'b0;
        repeat (15) begin
          samp();
          if (busy) any_busy = 1'b1;
        end
        check($sformatf("v%0d_nostart_busy", v), int'(any_busy), 0);
        check($sformatf("v%0d_nostart_bytes", v), rx.size() - rx0, 0);
        drive(); fifo_level = '0; cap_done = 1'b0; fifo_empty = 1'b1;
      end else begin
        run_frame(ok, nb);
        check($sformatf("v%0d_started", v), int'(ok), 1);
        check($sformatf("v%0d_busy_fall", v), int'(busy), 0);
        check_frame($sformatf("v%0d_frame", v), rx0,
                    model_frame(exp_seq, vecs[v].exp_n, vecs[v].exp_n, 1'b1));
        exp_seq = exp_seq + 8'd1;
        check($sformatf("v%0d_seq", v), int'(seq), int'(exp_seq));
        if (!vecs[v].bp) check($sformatf("v%0d_busy_cycles", v), nb, 6 * vecs[v].exp_n + 6);
      end
      drive(); bp_mode = 1'b0;
    end

    // Gating: enable low holds off, enable dropped mid-payload still completes the frame.
    load_words(1'b0);
    rd_base = read_cnt;
    rx0 = rx.size();
    drive(); enable = 1'b0; fifo_level = 14'd600; cap_done = 1'b0; fifo_empty = 1'b0;
    any_busy = 1'b0;
    repeat (30) begin
      samp();
      if (busy) any_busy = 1'b1;
    end
    check("gate_off_busy", int'(any_busy), 0);
    check("gate_off_bytes", rx.size() - rx0, 0);
    drive(); enable = 1'b1;
    wait_busy(ok);
    check("gate_started", int'(ok), 1);
    for (int i = 0; i < 100 && read_cnt - rd_base < 2; i++) samp();
    drive(); enable = 1'b0;
    wait_idle(nb);
    check("gate_busy_fall", int'(busy), 0);
    check_frame("gate_frame", rx0, model_frame(exp_seq, 4, 4, 1'b1));
    exp_seq = exp_seq + 8'd1;
    check("gate_seq", int'(seq), int'(exp_seq));
    rx0 = rx.size();
    any_busy = 1'b0;
    repeat (20) begin
      samp();
      if (busy) any_busy = 1'b1;
    end
    check("gate_no_restart", int'(any_busy) + rx.size() - rx0, 0);
    drive(); fifo_level = '0; fifo_empty = 1'b1;

    // Read timeout on the third word; second pass holds err_clr during the timeout cycle.
    for (int it = 0; it < 2; it++) begin
      load_words(1'b0);
      rd_base = read_cnt;
      supp_rd = rd_base + 2;
      rx0 = rx.size();
      drive(); enable = 1'b1; fifo_level = 14'd4; fifo_empty = 1'b0;
      wait_busy(ok);
      check($sformatf("to%0d_started", it), int'(ok), 1);
      drive(); fifo_level = '0; fifo_empty = 1'b1;
      for (int i = 0; i < 200 && read_cnt < rd_base + 3; i++) samp();
      check($sformatf("to%0d_reads", it), read_cnt - rd_base, 3);
      t = last_pulse_cyc;
      while (cyc < t + 15) drive();
      if (it == 1) err_clr = 1'b1;
      samp();
      check($sformatf("to%0d_err_early", it), int'(err), 0);
      check($sformatf("to%0d_busy_wait", it), int'(busy), 1);
      drive(); err_clr = 1'b0;
      samp();
      check($sformatf("to%0d_err_set", it), int'(err), 1);
      check($sformatf("to%0d_busy_fall", it), int'(busy), 0);
      check_frame($sformatf("to%0d_frame", it), rx0, model_frame(exp_seq, 4, 2, 1'b0));
      exp_seq = exp_seq + 8'd1;
      check($sformatf("to%0d_seq", it), int'(seq), int'(exp_seq));
      repeat (5) samp();
      check($sformatf("to%0d_err_sticky", it), int'(err), 1);
      drive(); err_clr = 1'b1;
      drive(); err_clr = 1'b0;
      samp();
      check($sformatf("to%0d_err_clr", it), int'(err), 0);
      supp_rd = -1;
    end

    // Reset asserted while payload byte 5 is on the bus.
    load_words(1'b0);
    rd_base = read_cnt;
    rx0 = rx.size();
    drive(); enable = 1'b1; fifo_level = 14'd4; fifo_empty = 1'b0;
    wait_busy(ok);
    drive(); fifo_level = '0; fifo_empty = 1'b1;
    for (int i = 0; i < 200 && rx.size() - rx0 < 10; i++) samp();
    check("rst_pos_bytes", rx.size() - rx0, 10);
    check("rst_pos_valid", int'(tx_valid), 1);
    if (rx.size() - rx0 >= 10) check("rst_pos_byte5", int'(rx[rx0 + 9]), int'(wtab[2][15:8]));
    rst = 1'b1;
    #1;
    check("rst_mid_re_pulse", int'(data_re_pulse), 0);
    check("rst_mid_tx_valid", int'(tx_valid), 0);
    check("rst_mid_tx_data", int'(tx_data), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_seq", int'(seq), 0);
    check("rst_mid_err", int'(err), 0);
    drive(); rst = 1'b0;
    exp_seq = '0;

    load_words(1'b1);
    rd_base = read_cnt;
    rx0 = rx.size();
    drive(); fifo_level = 14'd4; fifo_empty = 1'b0;
    run_frame(ok, nb);
    check("post_rst_started", int'(ok), 1);
    check_frame("post_rst_frame", rx0, model_frame(8'h00, 4, 4, 1'b1));
    check("post_rst_seq", int'(seq), 1);
    check("post_rst_busy_cycles", nb, 30);

    check("stall_hold_viol", stall_viol, 0);
    check("stall_exercised", int'(stall_seen > 0), 1);
    check("read_protocol_viol", proto_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
